// File: rtl/accum_seq_if.sv
// Handshake bundle between the accumulator sequencer and its neighbours.
// Carries the per-vector config channel, the MVM partial-sum stream, the
// accumulator drive signals and the status outputs. The master side is the
// environment, which drives config and stream; the slave side is the sequencer.
interface accum_seq_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 6,
    parameter int SUBW  = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ADDRW:0]   cfg_rows;
    logic [SUBW-1:0]  cfg_subsets;
    logic             cfg_err;
    logic             s_valid;
    logic             s_ready;
    logic [DATAW-1:0] s_data;
    logic             m_valid;
    logic [DATAW-1:0] m_data;
    logic [ADDRW-1:0] m_addr;
    logic             m_accum;
    logic             m_last;
    logic             busy;
    logic             done;
    logic [31:0]      stall_cnt;

    modport master (
        output cfg_valid, cfg_rows, cfg_subsets, s_valid, s_data,
        input  cfg_ready, cfg_err, s_ready, m_valid, m_data, m_addr,
               m_accum, m_last, busy, done, stall_cnt
    );

    modport slave (
        input  cfg_valid, cfg_rows, cfg_subsets, s_valid, s_data,
        output cfg_ready, cfg_err, s_ready, m_valid, m_data, m_addr,
               m_accum, m_last, busy, done, stall_cnt
    );
endinterface

// File: rtl/accum_seq_ctrl.sv
// Sequencer in front of one accumulator instance.
// Latches a per-vector config (rows per subset, subsets per vector), walks the
// accumulator address space as MVM partial sums arrive, and back-pressures the
// stream whenever a beat would read an address whose read-modify-write is
// still in flight. Pulses done once the last writes have drained.
// Optional build macro: ACCUM_CTRL_PERF_EN adds a saturating hazard-stall
// counter on stall_cnt; without it stall_cnt is constant zero.
module accum_seq_ctrl #(
    parameter int DATAW    = 32,
    parameter int DEPTH    = 64,
    parameter int ADDRW    = 6,
    parameter int SUBW     = 8,
    parameter int HAZ_DIST = 4
) (
    input  logic      clk,
    input  logic      rst,
    accum_seq_if.slave bus
);

    localparam int             CNTW     = $clog2(HAZ_DIST + 1);
    localparam logic [ADDRW:0] MAX_ROWS = (ADDRW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [ADDRW:0]   rows_q;
    logic [SUBW-1:0]  subsets_q;
    logic [ADDRW:0]   row_cnt;
    logic [SUBW-1:0]  sub_cnt;
    logic [CNTW-1:0]  drain_cnt;
    logic             err_pulse;
    logic             done_pulse;
    logic             acc_valid;
    logic [DATAW-1:0] acc_data;
    logic [ADDRW-1:0] acc_addr;
    logic             acc_accum;
    logic             acc_last;

    // Recent acceptances, index 0 = previous cycle, oldest at HAZ_DIST-2.
    logic             hist_vld  [HAZ_DIST-1];
    logic [ADDRW-1:0] hist_addr [HAZ_DIST-1];

    logic hazard;
    logic accept;
    logic cfg_ok;
    logic row_last;
    logic sub_last;

    assign cfg_ok   = (bus.cfg_rows != '0) && (bus.cfg_rows <= MAX_ROWS) && (bus.cfg_subsets != '0);
    assign row_last = (row_cnt == rows_q - (ADDRW + 1)'(1));
    assign sub_last = (sub_cnt == subsets_q - SUBW'(1));
    assign accept   = (state == RUN) && bus.s_valid && !hazard;

    assign bus.cfg_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.s_ready   = (state == RUN) && !hazard;
    assign bus.cfg_err   = err_pulse;
    assign bus.done      = done_pulse;
    assign bus.m_valid   = acc_valid;
    assign bus.m_data    = acc_data;
    assign bus.m_addr    = acc_addr;
    assign bus.m_accum   = acc_accum;
    assign bus.m_last    = acc_last;

    // Flag a read-after-write hazard: an accumulating beat targets an address written too recently.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DIST - 1; i++) begin
            if (hist_vld[i] && (hist_addr[i] == row_cnt[ADDRW-1:0])) begin
                hazard = 1'b1;
            end
        end
        if (sub_cnt == '0) begin
            hazard = 1'b0;
        end
    end

    // Shift acceptance history one slot per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HAZ_DIST - 1; i++) begin
                hist_vld[i]  <= 1'b0;
                hist_addr[i] <= '0;
            end
        end else begin
            hist_vld[0]  <= accept;
            hist_addr[0] <= row_cnt[ADDRW-1:0];
            for (int i = 1; i < HAZ_DIST - 1; i++) begin
                hist_vld[i]  <= hist_vld[i-1];
                hist_addr[i] <= hist_addr[i-1];
            end
        end
    end

    // Main FSM: config capture, row/subset walk with registered accumulator drive, drain and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rows_q     <= '0;
            subsets_q  <= '0;
            row_cnt    <= '0;
            sub_cnt    <= '0;
            drain_cnt  <= '0;
            err_pulse  <= 1'b0;
            done_pulse <= 1'b0;
            acc_valid  <= 1'b0;
            acc_data   <= '0;
            acc_addr   <= '0;
            acc_accum  <= 1'b0;
            acc_last   <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            done_pulse <= 1'b0;
            acc_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        if (cfg_ok) begin
                            rows_q    <= bus.cfg_rows;
                            subsets_q <= bus.cfg_subsets;
                            row_cnt   <= '0;
                            sub_cnt   <= '0;
                            state     <= RUN;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_valid <= 1'b1;
                        acc_data  <= bus.s_data;
                        acc_addr  <= row_cnt[ADDRW-1:0];
                        acc_accum <= (sub_cnt != '0);
                        acc_last  <= sub_last;
                        if (row_last) begin
                            row_cnt <= '0;
                            if (sub_last) begin
                                drain_cnt <= '0;
                                state     <= DRAIN;
                            end else begin
                                sub_cnt <= sub_cnt + SUBW'(1);
                            end
                        end else begin
                            row_cnt <= row_cnt + (ADDRW + 1)'(1);
                        end
                    end
                end
                DRAIN: begin
                    // drain_cnt is 0 in the cycle the final m_valid is visible.
                    drain_cnt <= drain_cnt + CNTW'(1);
                    if (drain_cnt == CNTW'(HAZ_DIST - 1)) begin
                        done_pulse <= 1'b1;
                    end
                    if (drain_cnt == CNTW'(HAZ_DIST)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACCUM_CTRL_PERF_EN
    logic [31:0] stall_q;

    assign bus.stall_cnt = stall_q;

    // Count RUN cycles where a beat is offered but held off by the hazard check.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && bus.cfg_valid && cfg_ok) begin
            stall_q <= '0;
        end else if ((state == RUN) && bus.s_valid && hazard && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl: a table of configurations with expected
// stream timing and stall counts, plus a hand-written reset-mid-vector sequence.
module tb_accum_seq_ctrl;

    localparam int DATAW    = 32;
    localparam int DEPTH    = 64;
    localparam int ADDRW    = 6;
    localparam int SUBW     = 8;
    localparam int HAZ_DIST = 4;

    typedef struct {
        int rows;
        int subsets;
        bit toggle;
        bit exp_err;
        int exp_span;
        int exp_stall;
    } vec_t;

    typedef struct {
        int               cyc;
        logic [ADDRW-1:0] addr;
        logic             accum;
        logic             last;
        logic [DATAW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    beat_t mon_q[$];

    accum_seq_if #(.DATAW(DATAW), .ADDRW(ADDRW), .SUBW(SUBW)) bus ();

    accum_seq_ctrl #(
        .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .SUBW(SUBW), .HAZ_DIST(HAZ_DIST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        if (bus.m_valid) begin
            b.cyc   = cyc;
            b.addr  = bus.m_addr;
            b.accum = bus.m_accum;
            b.last  = bus.m_last;
            b.data  = bus.m_data;
            mon_q.push_back(b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic run_err(input vec_t v);
        @(posedge clk); #1;
        bus.cfg_valid   = 1'b1;
        bus.cfg_rows    = (ADDRW + 1)'(v.rows);
        bus.cfg_subsets = SUBW'(v.subsets);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", longint'(bus.cfg_err), longint'(v.exp_err));
        chk("err_busy", longint'(bus.busy), 0);
        chk("err_s_ready", longint'(bus.s_ready), 0);
        chk("err_cfg_ready", longint'(bus.cfg_ready), 1);
        @(negedge clk);
        chk("cfg_err_one_cycle", longint'(bus.cfg_err), 0);
        chk("err_busy_later", longint'(bus.busy), 0);
    endtask

    task automatic run_stream(input vec_t v, input int idx);
        int               n;
        int               k;
        int               got;
        int               done_c;
        int               exp_stall;
        bit               accepted;
        int               acc_q[$];
        logic [DATAW-1:0] base;

        n    = v.rows * v.subsets;
        base = 32'hA000_0000 + 32'(idx * 256);
        mon_q.delete();

        @(posedge clk); #1;
        bus.cfg_valid   = 1'b1;
        bus.cfg_rows    = (ADDRW + 1)'(v.rows);
        bus.cfg_subsets = SUBW'(v.subsets);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        chk("busy_after_cfg", longint'(bus.busy), 1);
        chk("cfg_ready_run", longint'(bus.cfg_ready), 0);

        k = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = base;
        for (int c = 0; c < 4000 && k < n; c++) begin
            @(negedge clk);
            accepted = bus.s_valid && bus.s_ready;
            if (accepted) begin
                acc_q.push_back(cyc);
                k++;
            end
            @(posedge clk); #1;
            if (k >= n) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_data  = base + 32'(k);
                bus.s_valid = (v.toggle && accepted) ? 1'b0 : 1'b1;
            end
        end
        chk("beats_accepted", k, n);

        got    = 0;
        done_c = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got    = 1;
                done_c = cyc;
                break;
            end
        end
        chk("done_seen", got, 1);

        chk("m_valid_count", mon_q.size(), n);
        if (mon_q.size() == n && acc_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk("m_addr", longint'(mon_q[i].addr), i % v.rows);
                chk("m_accum", longint'(mon_q[i].accum), ((i / v.rows) != 0) ? 1 : 0);
                chk("m_last", longint'(mon_q[i].last), ((i / v.rows) == v.subsets - 1) ? 1 : 0);
                chk("m_data", longint'(mon_q[i].data), longint'(base + 32'(i)));
                chk("m_valid_lag", mon_q[i].cyc - acc_q[i], 1);
            end
            chk("accept_span", acc_q[n-1] - acc_q[0], v.exp_span);
            chk("done_latency", done_c - mon_q[n-1].cyc, HAZ_DIST);
        end

`ifdef ACCUM_CTRL_PERF_EN
        exp_stall = v.exp_stall;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", longint'(bus.stall_cnt), exp_stall);

        @(negedge clk);
        chk("done_one_cycle", longint'(bus.done), 0);
        chk("cfg_ready_after_done", longint'(bus.cfg_ready), 1);
        chk("busy_after_done", longint'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t fresh;
        int   k;
        int   done_seen;

        tbl[0] = '{rows: 4,  subsets: 3, toggle: 0, exp_err: 0, exp_span: 11, exp_stall: 0};
        tbl[1] = '{rows: 1,  subsets: 3, toggle: 0, exp_err: 0, exp_span: 8,  exp_stall: 6};
        tbl[2] = '{rows: 2,  subsets: 2, toggle: 0, exp_err: 0, exp_span: 5,  exp_stall: 2};
        tbl[3] = '{rows: 4,  subsets: 2, toggle: 1, exp_err: 0, exp_span: 14, exp_stall: 0};
        tbl[4] = '{rows: 3,  subsets: 2, toggle: 0, exp_err: 0, exp_span: 6,  exp_stall: 1};
        tbl[5] = '{rows: 64, subsets: 1, toggle: 0, exp_err: 0, exp_span: 63, exp_stall: 0};
        tbl[6] = '{rows: 0,  subsets: 1, toggle: 0, exp_err: 1, exp_span: 0,  exp_stall: 0};
        tbl[7] = '{rows: 65, subsets: 1, toggle: 0, exp_err: 1, exp_span: 0,  exp_stall: 0};
        tbl[8] = '{rows: 4,  subsets: 0, toggle: 0, exp_err: 1, exp_span: 0,  exp_stall: 0};

        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_rows    = '0;
        bus.cfg_subsets = '0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_cfg_ready", longint'(bus.cfg_ready), 1);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_s_ready", longint'(bus.s_ready), 0);
        chk("rst_m_valid", longint'(bus.m_valid), 0);
        chk("rst_m_addr", longint'(bus.m_addr), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_cfg_err", longint'(bus.cfg_err), 0);
        chk("rst_stall_cnt", longint'(bus.stall_cnt), 0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].exp_err) run_err(tbl[i]);
            else                run_stream(tbl[i], i);
        end

        // Reset lands in the cycle the 5th beat of rows=4, subsets=3 is accepted.
        @(posedge clk); #1;
        bus.cfg_valid   = 1'b1;
        bus.cfg_rows    = 7'd4;
        bus.cfg_subsets = 8'd3;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        bus.s_valid   = 1'b1;
        bus.s_data    = 32'h5000_0000;
        k = 0;
        for (int c = 0; c < 50 && k < 4; c++) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) k++;
            @(posedge clk); #1;
            bus.s_data = 32'h5000_0000 + 32'(k);
        end
        chk("rst_seq_pre_beats", k, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", longint'(bus.m_valid), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_cfg_ready", longint'(bus.cfg_ready), 1);
        chk("midrst_stall_cnt", longint'(bus.stall_cnt), 0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);

        fresh = '{rows: 2, subsets: 1, toggle: 0, exp_err: 0, exp_span: 1, exp_stall: 0};
        run_stream(fresh, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
